fifo_drain_arbiter: RTL and testbench

//  Round-robin read-side scheduler for NPORTS async_fifo instances that share one read clock.

---
 rtl/fifo_drain_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - round-robin burst drainer for FWFT FIFOs sharing one read clock
module fifo_drain_arbiter #(
    parameter int DSIZE  = 8,
    parameter int NPORTS = 4,
    parameter int BURST  = 4,
    localparam int SRCW  = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NPORTS-1:0]       fifo_rempty,
    input  logic [NPORTS*DSIZE-1:0] fifo_rdata,
    output logic [NPORTS-1:0]       fifo_rreq,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DSIZE-1:0]        out_data,
    output logic [SRCW-1:0]         out_src,
    output logic                    busy
);
    localparam int CNTW = $clog2(BURST + 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BURST} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_init_cnt;
    logic [SRCW-1:0]   r_rr_ptr;
    logic [SRCW-1:0]   r_grant;
    logic [CNTW-1:0]   r_cnt;
    logic              r_out_valid;
    logic [DSIZE-1:0]  r_out_data;
    logic [SRCW-1:0]   r_out_src;

    logic              w_found;
    logic [SRCW-1:0]   w_scan_grant;
    logic [SRCW-1:0]   w_rr_nxt;
    logic              w_gnt_empty;
    logic [DSIZE-1:0]  w_gnt_data;
    logic              w_pop;
    logic              w_last;
    logic              w_exit;

    function automatic logic [SRCW-1:0] wrap_add(input logic [SRCW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NPORTS) s = s - NPORTS;
        return SRCW'(s);
    endfunction

    // Descending scan so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_found      = 1'b0;
        w_scan_grant = r_rr_ptr;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (!fifo_rempty[wrap_add(r_rr_ptr, k)]) begin
                w_found      = 1'b1;
                w_scan_grant = wrap_add(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (r_grant == SRCW'(i)) w_gnt_data = fifo_rdata[i*DSIZE +: DSIZE];
        end
    end

    assign w_rr_nxt    = wrap_add(r_grant, 1);
    assign w_gnt_empty = fifo_rempty[r_grant];
    assign w_pop       = (r_state == S_BURST) && en && !w_gnt_empty && (!r_out_valid || out_ready);
    assign w_last      = w_pop && (r_cnt == CNTW'(BURST - 1));
    assign w_exit      = w_last || (en && w_gnt_empty);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (r_init_cnt)      w_state_nxt = S_IDLE;
            S_IDLE:  if (en && w_found)   w_state_nxt = S_BURST;
            S_BURST: if (w_exit)          w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        fifo_rreq = '0;
        if (!rst && w_pop) fifo_rreq[r_grant] = 1'b1;
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt  <= 1'b0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else begin
            if (r_state == S_INIT) r_init_cnt <= 1'b1;
            if (r_state == S_IDLE && en && w_found) begin
                r_grant <= w_scan_grant;
                r_cnt   <= '0;
            end
            if (w_pop) r_cnt <= r_cnt + CNTW'(1);
            if (r_state == S_BURST && w_exit) r_rr_ptr <= w_rr_nxt;
            if (w_pop) begin
                r_out_data  <= w_gnt_data;
                r_out_src   <= r_grant;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - directed bench for fifo_drain_arbiter with FWFT FIFO models
module tb_fifo_drain_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        out_ready;
    logic [3:0]  fifo_rempty;
    logic [31:0] fifo_rdata;
    logic [3:0]  fifo_rreq;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_src;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fmem [4][64];
    logic [5:0] fhead [4] = '{6'd0, 6'd0, 6'd0, 6'd0};
    logic [5:0] ftail [4] = '{6'd0, 6'd0, 6'd0, 6'd0};
    logic [9:0] acc [$];

    fifo_drain_arbiter #(.DSIZE(8), .NPORTS(4), .BURST(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rreq(fifo_rreq),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (fifo_rreq[i]) fhead[i] <= fhead[i] + 6'd1;
    end

    always_comb begin
        fifo_rempty = '0;
        fifo_rdata  = '0;
        for (int i = 0; i < 4; i++) begin
            fifo_rempty[i]        = (fhead[i] == ftail[i]);
            fifo_rdata[i*8 +: 8]  = fmem[i][fhead[i]];
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) acc.push_back({out_src, out_data});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int p, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            fmem[p][ftail[p]] = 8'(p*16 + first + k);
            ftail[p] = ftail[p] + 6'd1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        for (int p = 0; p < 4; p++) ftail[p] = fhead[p];
        en = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; out_ready = 1'b1;
        for (int p = 0; p < 4; p++) load(p, 0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
            n_checks++; if (fifo_rreq !== 4'b0000) $display("FAIL reset_rreq: got %b expected 0000", fifo_rreq); else n_pass++;
            n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else n_pass++;
        end
        n_checks++; if (out_data !== 8'h00 || out_src !== 2'd0) $display("FAIL reset_data: got %h/%0d expected 00/0", out_data, out_src); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (fifo_rreq !== 4'b0000) $display("FAIL init_rreq0: got %b expected 0000", fifo_rreq); else n_pass++;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (fifo_rreq !== 4'b0000 || out_valid !== 1'b0) $display("FAIL init_quiet: got rreq=%b valid=%b expected 0000/0", fifo_rreq, out_valid); else n_pass++;
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
        tick();
        n_checks++; if (fifo_rreq !== 4'b0001) $display("FAIL first_grant: got %b expected 0001", fifo_rreq); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_src !== 2'd0) $display("FAIL first_word: got v=%b %h/%0d expected 1 00/0", out_valid, out_data, out_src); else n_pass++;
    endtask

    task automatic test_single_source();
        apply_reset();
        load(0, 0, 3);
        tick();
        n_checks++; if (fifo_rreq !== 4'b0001) $display("FAIL t2_rreq: got %b expected 0001", fifo_rreq); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 8'(k) || out_src !== 2'd0) $display("FAIL t2_word%0d: got v=%b %h/%0d expected 1 %h/0", k, out_valid, out_data, out_src, 8'(k)); else n_pass++;
        end
        tick();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL t2_idle: got busy=%b valid=%b expected 0/0", busy, out_valid); else n_pass++;
        load(0, 3, 1);
        load(1, 0, 1);
        tick();
        n_checks++; if (fifo_rreq !== 4'b0010) $display("FAIL t2_rr_ptr: got %b expected 0010", fifo_rreq); else n_pass++;
        tick();
        n_checks++; if (out_data !== 8'h10 || out_src !== 2'd1) $display("FAIL t2_port1: got %h/%0d expected 10/1", out_data, out_src); else n_pass++;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (out_data !== 8'h03 || out_src !== 2'd0) $display("FAIL t2_wrap: got %h/%0d expected 03/0", out_data, out_src); else n_pass++;
    endtask

    task automatic test_round_robin();
        int st;
        apply_reset();
        st = acc.size();
        for (int p = 0; p < 4; p++) load(p, 0, 8);
        for (int i = 0; i < 50; i++) tick();
        n_checks++; if (acc.size() - st !== 32) $display("FAIL t3_count: got %0d expected 32", acc.size() - st); else n_pass++;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                for (int k = 0; k < 4; k++) begin
                    logic [9:0] e;
                    e = {2'(p), 8'(p*16 + r*4 + k)};
                    n_checks++;
                    if (acc[st + r*16 + p*4 + k] !== e) $display("FAIL t3_seq%0d: got %h expected %h", r*16 + p*4 + k, acc[st + r*16 + p*4 + k], e); else n_pass++;
                end
        n_checks++; if (busy !== 1'b0) $display("FAIL t3_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int st;
        apply_reset();
        st = acc.size();
        load(0, 0, 4);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (fifo_rreq !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h01) $display("FAIL t4_hold%0d: got rreq=%b v=%b %h expected 0000/1/01", i, fifo_rreq, out_valid, out_data); else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (acc.size() - st !== 4) $display("FAIL t4_count: got %0d expected 4", acc.size() - st); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (acc[st + k] !== {2'd0, 8'(k)}) $display("FAIL t4_word%0d: got %h expected %h", k, acc[st + k], {2'd0, 8'(k)}); else n_pass++;
        end
    endtask

    task automatic test_mid_burst_reset();
        apply_reset();
        load(0, 0, 4);
        load(1, 0, 4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if (fifo_rreq !== 4'b0000) $display("FAIL t5_rreq_comb: got %b expected 0000", fifo_rreq); else n_pass++;
        #1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || fifo_rreq !== 4'b0000) $display("FAIL t5_flush: got v=%b rreq=%b expected 0/0000", out_valid, fifo_rreq); else n_pass++;
        rst = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (fifo_rreq !== 4'b0001) $display("FAIL t5_regrant: got %b expected 0001", fifo_rreq); else n_pass++;
        tick();
        n_checks++; if (out_data !== 8'h02 || out_src !== 2'd0) $display("FAIL t5_resume: got %h/%0d expected 02/0", out_data, out_src); else n_pass++;
    endtask

    task automatic test_en_gating();
        int st;
        logic [9:0] exp_q [8];
        exp_q = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h110, 10'h111, 10'h004, 10'h005};
        apply_reset();
        st = acc.size();
        load(0, 0, 6);
        load(1, 0, 2);
        tick();
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (fifo_rreq !== 4'b0000 || busy !== 1'b1) $display("FAIL t6_frozen%0d: got rreq=%b busy=%b expected 0000/1", i, fifo_rreq, busy); else n_pass++;
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++; if (acc.size() - st !== 8) $display("FAIL t6_count: got %0d expected 8", acc.size() - st); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (acc[st + k] !== exp_q[k]) $display("FAIL t6_seq%0d: got %h expected %h", k, acc[st + k], exp_q[k]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_mid_burst_reset();
        test_en_gating();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
